// File: rtl/systolic_cacc_if.sv
// Partial-sum ingress and finished-sum egress bundle for systolic_cacc.
interface systolic_cacc_if #(
    parameter int TOUT   = 4,
    parameter int IN_DW  = 20,
    parameter int ACC_DW = 32
);
    logic                     in_vld;
    logic [TOUT*IN_DW-1:0]    in_dat;
    logic                     out_vld;
    logic [TOUT*ACC_DW-1:0]   out_dat;
    logic                     out_rdy;

    modport master (output in_vld, in_dat, out_rdy, input out_vld, out_dat);
    modport slave  (input in_vld, in_dat, out_rdy, output out_vld, out_dat);
endinterface

// File: rtl/systolic_cacc.sv
// Channel accumulator: sums per-pixel partial sums across Tin chunks with
// saturation, then queues finished pixels in a small output FIFO.
module systolic_cacc #(
    parameter int TOUT       = 4,
    parameter int IN_DW      = 20,
    parameter int ACC_DW     = 32,
    parameter int WOUT_MAX   = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_start,
    input  logic [$clog2(WOUT_MAX+1)-1:0]  cfg_wout,
    input  logic [7:0]                     cfg_tin_chunks,
    systolic_cacc_if.slave                 bus,
    output logic                           busy,
    output logic                           done,
    output logic                           err_ovf
);
    localparam int WW = $clog2(WOUT_MAX + 1);
    localparam int AW = (WOUT_MAX > 1) ? $clog2(WOUT_MAX) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = TOUT * ACC_DW;
    localparam int SW = ACC_DW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t           r_state;
    logic [WW-1:0]    r_wout, r_pix_cnt;
    logic [7:0]       r_chunks, r_chunk_cnt;
    logic [DW-1:0]    r_buf  [WOUT_MAX];
    logic [DW-1:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_busy, r_done, r_err_ovf;

    logic             w_beat, w_last_pix, w_last_chunk, w_cfg_ok;
    logic             w_push, w_pop, w_full, w_drop, w_push_ok;
    logic [DW-1:0]    w_base, w_sum;
    logic signed [SW-1:0] w_acc;

    function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_beat       = (r_state == S_RUN) && bus.in_vld;
    assign w_last_pix   = (r_pix_cnt == r_wout - WW'(1));
    assign w_last_chunk = (r_chunk_cnt == r_chunks - 8'd1);
    assign w_cfg_ok     = (cfg_wout != '0) && (cfg_wout <= WW'(WOUT_MAX)) &&
                          (cfg_tin_chunks != '0);
    assign w_pop        = (r_count != '0) && bus.out_rdy;
    assign w_full       = (r_count == CW'(FIFO_DEPTH));
    assign w_push       = w_beat && w_last_chunk;
    assign w_drop       = w_push && w_full && !w_pop;
    assign w_push_ok    = w_push && !w_drop;

    // Chunk 0 ignores the buffer, so it never needs initialising.
    always_comb begin
        w_base = (r_chunk_cnt == '0) ? '0 : r_buf[r_pix_cnt[AW-1:0]];
        w_sum  = '0;
        w_acc  = '0;
        for (int unsigned k = 0; k < TOUT; k++) begin
            w_acc = SW'($signed(w_base[k*ACC_DW +: ACC_DW])) +
                    SW'($signed(bus.in_dat[k*IN_DW +: IN_DW]));
            if (w_acc[ACC_DW] != w_acc[ACC_DW-1])
                w_sum[k*ACC_DW +: ACC_DW] = w_acc[ACC_DW] ? {1'b1, {(ACC_DW-1){1'b0}}}
                                                          : {1'b0, {(ACC_DW-1){1'b1}}};
            else
                w_sum[k*ACC_DW +: ACC_DW] = w_acc[ACC_DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat && !w_last_chunk)
            r_buf[r_pix_cnt[AW-1:0]] <= w_sum;
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_fifo[r_wr_ptr] <= w_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= f_nxt(r_wr_ptr);
            if (w_pop)     r_rd_ptr <= f_nxt(r_rd_ptr);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wout      <= '0;
            r_chunks    <= '0;
            r_pix_cnt   <= '0;
            r_chunk_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_drop) r_err_ovf <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (cfg_start && w_cfg_ok) begin
                        r_wout      <= cfg_wout;
                        r_chunks    <= cfg_tin_chunks;
                        r_pix_cnt   <= '0;
                        r_chunk_cnt <= '0;
                        r_err_ovf   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.in_vld) begin
                        if (w_last_pix) begin
                            r_pix_cnt   <= '0;
                            r_chunk_cnt <= r_chunk_cnt + 8'd1;
                            if (w_last_chunk) r_state <= S_DRAIN;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + WW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_count == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_vld = (r_count != '0);
    assign bus.out_dat = bus.out_vld ? r_fifo[r_rd_ptr] : '0;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_ovf     = r_err_ovf;
endmodule

// File: tb/tb_systolic_cacc.sv
// Directed bench for systolic_cacc: a default build plus an ACC_DW=21 build
// fed identical stimulus so saturation can be observed.
module tb_systolic_cacc;
    logic        clk = 1'b0;
    logic        rst, cfg_start, in_vld, out_rdy;
    logic [6:0]  cfg_wout;
    logic [7:0]  cfg_tin_chunks;
    logic [79:0] in_dat;
    logic        busy, done, err_ovf, s_busy, s_done, s_err_ovf;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    systolic_cacc_if #(.TOUT(4), .IN_DW(20), .ACC_DW(32)) bus ();
    systolic_cacc_if #(.TOUT(4), .IN_DW(20), .ACC_DW(21)) sbus ();

    assign bus.in_vld   = in_vld;
    assign bus.in_dat   = in_dat;
    assign bus.out_rdy  = out_rdy;
    assign sbus.in_vld  = in_vld;
    assign sbus.in_dat  = in_dat;
    assign sbus.out_rdy = out_rdy;

    systolic_cacc #(.TOUT(4), .IN_DW(20), .ACC_DW(32), .WOUT_MAX(64), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_wout(cfg_wout),
        .cfg_tin_chunks(cfg_tin_chunks), .bus(bus),
        .busy(busy), .done(done), .err_ovf(err_ovf)
    );

    systolic_cacc #(.TOUT(4), .IN_DW(20), .ACC_DW(21), .WOUT_MAX(64), .FIFO_DEPTH(4)) u_sat (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_wout(cfg_wout),
        .cfg_tin_chunks(cfg_tin_chunks), .bus(sbus),
        .busy(s_busy), .done(s_done), .err_ovf(s_err_ovf)
    );

    function automatic logic [79:0] pk(input int a, input int b, input int c, input int d);
        return {20'(d), 20'(c), 20'(b), 20'(a)};
    endfunction
    function automatic logic [127:0] ex(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction
    function automatic logic [83:0] exs(input int a, input int b, input int c, input int d);
        return {21'(d), 21'(c), 21'(b), 21'(a)};
    endfunction
    function automatic logic [79:0] pd(input int i);
        return pk(10*i, 10*i+1, 10*i+2, 10*i+3);
    endfunction
    function automatic logic [127:0] ed(input int i);
        return ex(10*i, 10*i+1, 10*i+2, 10*i+3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int w, input int c);
        cfg_start      = 1'b1;
        cfg_wout       = 7'(w);
        cfg_tin_chunks = 8'(c);
        tick();
        cfg_start      = 1'b0;
    endtask

    task automatic beat(input logic [79:0] d);
        in_vld = 1'b1;
        in_dat = d;
        tick();
        in_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_sdone"}, s_done, 1'b1);
        tick();
        chk({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cfg_start = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
        cfg_wout = '0; cfg_tin_chunks = '0; in_dat = '0;
        tick(); tick();
        chk("rst_vld", bus.out_vld, 1'b0);
        chk("rst_dat", bus.out_dat, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", err_ovf, 1'b0);
        rst = 1'b0;
        tick();

        // single chunk, pass-through with one-cycle latency
        start(3, 1);
        chk("a_busy", busy, 1'b1);
        beat(pk(1, 1, 1, 1));
        chk("a_vld0", bus.out_vld, 1'b1);
        chk("a_dat0", bus.out_dat, ex(1, 1, 1, 1));
        beat(pk(2, 2, 2, 2));
        chk("a_dat1", bus.out_dat, ex(2, 2, 2, 2));
        beat(pk(3, 3, 3, 3));
        chk("a_dat2", bus.out_dat, ex(3, 3, 3, 3));
        chk("a_sdat2", sbus.out_dat, exs(3, 3, 3, 3));
        chk("a_drain_busy", busy, 1'b1);
        tick();
        chk("a_empty", bus.out_vld, 1'b0);
        chk("a_nodone", done, 1'b0);
        wait_done("a");

        // three chunks over two pixels
        start(2, 3);
        beat(pk(-5, -5, -5, -5)); beat(pk(-5, -5, -5, -5));
        beat(pk(7, 7, 7, 7));     beat(pk(7, 7, 7, 7));
        chk("b_novld", bus.out_vld, 1'b0);
        beat(pk(100, 100, 100, 100));
        chk("b_dat0", bus.out_dat, ex(102, 102, 102, 102));
        beat(pk(100, 100, 100, 100));
        chk("b_dat1", bus.out_dat, ex(102, 102, 102, 102));
        chk("b_sdat1", sbus.out_dat, exs(102, 102, 102, 102));
        wait_done("b");

        // same-pixel read-modify-write
        start(1, 4);
        beat(pk(1, 1, 1, 1)); beat(pk(1, 1, 1, 1)); beat(pk(1, 1, 1, 1));
        chk("c_novld", bus.out_vld, 1'b0);
        beat(pk(1, 1, 1, 1));
        chk("c_dat", bus.out_dat, ex(4, 4, 4, 4));
        wait_done("c");

        // FIFO overflow with stalled consumer
        out_rdy = 1'b0;
        start(6, 1);
        for (int i = 0; i < 4; i++) beat(pd(i));
        chk("d_ovf_before", err_ovf, 1'b0);
        chk("d_head", bus.out_dat, ed(0));
        beat(pd(4));
        chk("d_ovf", err_ovf, 1'b1);
        beat(pd(5));
        chk("d_busy", busy, 1'b1);
        tick(); tick(); tick();
        chk("d_hold_done", done, 1'b0);
        chk("d_hold_dat", bus.out_dat, ed(0));
        out_rdy = 1'b1;
        tick();
        chk("d_pop1", bus.out_dat, ed(1));
        tick();
        chk("d_pop2", bus.out_dat, ed(2));
        tick();
        chk("d_pop3", bus.out_dat, ed(3));
        tick();
        chk("d_empty", bus.out_vld, 1'b0);
        chk("d_nodone", done, 1'b0);
        tick();
        chk("d_done", done, 1'b1);
        chk("d_idle", busy, 1'b0);
        chk("d_sticky", err_ovf, 1'b1);
        tick();

        // out-of-range configs are ignored and leave the sticky flag alone
        start(0, 1);
        chk("i_w0_busy", busy, 1'b0);
        start(2, 0);
        chk("i_c0_busy", busy, 1'b0);
        start(65, 1);
        chk("i_w65_busy", busy, 1'b0);
        chk("i_done", done, 1'b0);
        chk("i_ovf", err_ovf, 1'b1);

        // push into a full FIFO while popping is accepted
        out_rdy = 1'b0;
        start(5, 1);
        chk("g_ovf_clr", err_ovf, 1'b0);
        for (int i = 0; i < 4; i++) beat(pd(i));
        out_rdy = 1'b1;
        beat(pd(4));
        chk("g_ovf", err_ovf, 1'b0);
        chk("g_pop1", bus.out_dat, ed(1));
        tick(); tick(); tick();
        chk("g_last", bus.out_dat, ed(4));
        wait_done("g");

        // saturation in the narrow build, exact sums in the wide build
        start(1, 3);
        chk("e_sovf_clr", s_err_ovf, 1'b0);
        for (int i = 0; i < 3; i++) beat(pk(524287, -524288, 1, -1));
        chk("e_wide", bus.out_dat, ex(1572861, -1572864, 3, -3));
        chk("e_sat", sbus.out_dat, exs(1048575, -1048576, 3, -3));
        wait_done("e");

        // reset mid-pass, then a clean pass
        start(2, 2);
        beat(pk(5, 5, 5, 5)); beat(pk(5, 5, 5, 5)); beat(pk(7, 7, 7, 7));
        chk("f_pre_dat", bus.out_dat, ex(12, 12, 12, 12));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("f_rst_vld", bus.out_vld, 1'b0);
        chk("f_rst_dat", bus.out_dat, '0);
        chk("f_rst_busy", busy, 1'b0);
        tick(); tick();
        chk("f_rst_nodone", done, 1'b0);
        beat(pk(99, 99, 99, 99));
        chk("f_idle_vld", bus.out_vld, 1'b0);
        chk("f_idle_busy", busy, 1'b0);
        start(2, 2);
        beat(pk(3, -3, 100, -100));
        cfg_start = 1'b1; cfg_wout = 7'd1; cfg_tin_chunks = 8'd1;
        beat(pk(-4, 4, 0, 1));
        cfg_start = 1'b0;
        chk("f_run_novld", bus.out_vld, 1'b0);
        beat(pk(10, 10, 10, 10));
        chk("f_dat0", bus.out_dat, ex(13, 7, 110, -90));
        beat(pk(20, 20, 20, 20));
        chk("f_dat1", bus.out_dat, ex(16, 24, 20, 21));
        wait_done("f");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
